// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit pipelined core: widths, ALU opcodes,
// the EX/MEM payload and the multiplier FSM states.
package core_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned IMM_W  = 5;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'h2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'h3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [OP_W-1:0] ALU_NOT  = 4'h5;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'h6;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'h7;
    localparam logic [OP_W-1:0] ALU_ADDI = 4'h8;
    localparam logic [OP_W-1:0] ALU_LI   = 4'h9;
    localparam logic [OP_W-1:0] ALU_MOV  = 4'hA;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'hB;
    localparam logic [OP_W-1:0] ALU_SEQ  = 4'hC;
    localparam logic [OP_W-1:0] ALU_MUL  = 4'hD;

    // Contents of the EX/MEM pipeline register
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store;
        logic [REG_AW-1:0] waddr;
        logic              regwrite;
        logic              wdc;
        logic              memwrite;
        logic              memread;
    } ex_mem_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU: result and the candidate CB flag value.
module alu8
    import core_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] result_c,
    output logic              cb_next_c
);

    logic [DATA_W-1:0] imm_ext;
    logic [2:0]        shamt;

    assign imm_ext = DATA_W'(imm);
    assign shamt   = imm[2:0];

    always_comb begin
        result_c = '0;
        case (op)
            ALU_ADD:  result_c = a + b;
            ALU_SUB:  result_c = a - b;
            ALU_AND:  result_c = a & b;
            ALU_OR:   result_c = a | b;
            ALU_XOR:  result_c = a ^ b;
            ALU_NOT:  result_c = ~a;
            ALU_SLL:  result_c = a << shamt;
            ALU_SRL:  result_c = a >> shamt;
            ALU_ADDI: result_c = a + imm_ext;
            ALU_LI:   result_c = imm_ext;
            ALU_MOV:  result_c = b;
            default:  result_c = '0;
        endcase
    end

    // Compares produce their own flag; everything else flags a zero result
    always_comb begin
        cb_next_c = (result_c == '0);
        case (op)
            ALU_SLT: cb_next_c = (a < b);
            ALU_SEQ: cb_next_c = (a == b);
            default: cb_next_c = (result_c == '0);
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding and the EX/MEM pipeline register.
// Optional shift-add multiplier for opcode D when MUL_EN is defined.
module ex_mem_stage
    import core_pkg::*;
`ifdef MUL_EN
#(
    parameter int unsigned MUL_CYCLES = 8
)
`endif
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [OP_W-1:0]   alucontrol_i,
    input  logic              regwrite_i,
    input  logic              write_data_control_i,
    input  logic              CBwrite_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [REG_AW-1:0] rt_addr_i,
    input  logic [REG_AW-1:0] write_addr_i,
    input  logic [IMM_W-1:0]  immediate_i,
    input  logic              memwrite_i,
    input  logic              memread_i,
    input  logic              done_i,
    input  logic              wb_regwrite_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_AW-1:0] write_addr_o,
    output logic              regwrite_o,
    output logic              write_data_control_o,
    output logic              memwrite_o,
    output logic              memread_o,
    output logic              cb_o,
    output logic              done_o,
    output logic              busy_o
);

    ex_mem_t           q_q;
    ex_mem_t           q_d;
    ex_mem_t           ex_next;
    logic              q_we;
    logic              cb_q;
    logic              cb_d;
    logic              cb_we;
    logic              done_q;
    logic              done_set;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cb;
    logic              exm_fwd_ok;

    // Only a non-load EX/MEM result is available for forwarding
    assign exm_fwd_ok = q_q.regwrite && !q_q.wdc;

    always_comb begin
        rs_fwd = rs_data_i;
        if (exm_fwd_ok && (q_q.waddr == rs_addr_i)) begin
            rs_fwd = q_q.result;
        end else if (wb_regwrite_i && (wb_addr_i == rs_addr_i)) begin
            rs_fwd = wb_data_i;
        end
    end

    always_comb begin
        rt_fwd = rt_data_i;
        if (exm_fwd_ok && (q_q.waddr == rt_addr_i)) begin
            rt_fwd = q_q.result;
        end else if (wb_regwrite_i && (wb_addr_i == rt_addr_i)) begin
            rt_fwd = wb_data_i;
        end
    end

    alu8 u_alu (
        .op        (alucontrol_i),
        .a         (rs_fwd),
        .b         (rt_fwd),
        .imm       (immediate_i),
        .result_c  (alu_res),
        .cb_next_c (alu_cb)
    );

    always_comb begin
        ex_next.result   = alu_res;
        ex_next.store    = rt_fwd;
        ex_next.waddr    = write_addr_i;
        ex_next.regwrite = regwrite_i;
        ex_next.wdc      = write_data_control_i;
        ex_next.memwrite = memwrite_i;
        ex_next.memread  = memread_i;
    end

`ifdef MUL_EN
    localparam int unsigned CNT_W = $clog2(MUL_CYCLES) + 1;

    mul_state_e        state_q;
    mul_state_e        state_d;
    logic              mul_start;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] held_store_q;
    logic [REG_AW-1:0] held_waddr_q;
    logic              held_rw_q;
    logic              held_wdc_q;
    logic              held_mw_q;
    logic              held_mr_q;
    logic              held_cbw_q;
    logic              held_done_q;
    logic              busy_q;
`endif

    // Next-state and EX/MEM load control
    always_comb begin
        q_we     = 1'b0;
        q_d      = q_q;
        cb_we    = 1'b0;
        cb_d     = alu_cb;
        done_set = 1'b0;
`ifdef MUL_EN
        state_d   = state_q;
        mul_start = 1'b0;
        if (!stall_i) begin
            q_we = 1'b1;
            q_d  = '0;
            case (state_q)
                S_IDLE: begin
                    if (!flush_i) begin
                        if (alucontrol_i == ALU_MUL) begin
                            state_d   = S_RUN;
                            mul_start = 1'b1;
                        end else begin
                            q_d      = ex_next;
                            cb_we    = CBwrite_i;
                            done_set = done_i;
                        end
                    end
                end
                S_RUN: begin
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    if (!flush_i) begin
                        q_d.result   = acc_q;
                        q_d.store    = held_store_q;
                        q_d.waddr    = held_waddr_q;
                        q_d.regwrite = held_rw_q;
                        q_d.wdc      = held_wdc_q;
                        q_d.memwrite = held_mw_q;
                        q_d.memread  = held_mr_q;
                        cb_we        = held_cbw_q;
                        cb_d         = (acc_q == '0);
                        done_set     = held_done_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
`else
        if (!stall_i) begin
            q_we = 1'b1;
            if (flush_i) begin
                q_d = '0;
            end else begin
                q_d      = ex_next;
                cb_we    = CBwrite_i;
                done_set = done_i;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q    <= '0;
            cb_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (q_we) q_q <= q_d;
            if (cb_we) cb_q <= cb_d;
            if (done_set) done_q <= 1'b1;
        end
    end

`ifdef MUL_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // Operand capture at acceptance, then one shift-add step per RUN cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            held_store_q <= '0;
            held_waddr_q <= '0;
            held_rw_q    <= 1'b0;
            held_wdc_q   <= 1'b0;
            held_mw_q    <= 1'b0;
            held_mr_q    <= 1'b0;
            held_cbw_q   <= 1'b0;
            held_done_q  <= 1'b0;
        end else if (mul_start) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            mcand_q      <= rs_fwd;
            mplier_q     <= rt_fwd;
            held_store_q <= rt_fwd;
            held_waddr_q <= write_addr_i;
            held_rw_q    <= regwrite_i;
            held_wdc_q   <= write_data_control_i;
            held_mw_q    <= memwrite_i;
            held_mr_q    <= memread_i;
            held_cbw_q   <= CBwrite_i;
            held_done_q  <= done_i;
        end else if ((state_q == S_RUN) && !stall_i && !flush_i) begin
            cnt_q    <= cnt_q + CNT_W'(1);
            acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign busy_o = busy_q;
`else
    assign busy_o = 1'b0;
`endif

    assign alu_result_o         = q_q.result;
    assign store_data_o         = q_q.store;
    assign write_addr_o         = q_q.waddr;
    assign regwrite_o           = q_q.regwrite;
    assign write_data_control_o = q_q.wdc;
    assign memwrite_o           = q_q.memwrite;
    assign memread_o            = q_q.memread;
    assign cb_o                 = cb_q;
    assign done_o               = done_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random
// instruction streams against a behavioural model of the stage.
module tb_ex_mem_stage;

    logic       clk_i = 1'b0;
    logic       rst_i, stall_i, flush_i;
    logic [3:0] alucontrol_i;
    logic       regwrite_i, write_data_control_i, CBwrite_i;
    logic [7:0] rs_data_i, rt_data_i;
    logic [2:0] rs_addr_i, rt_addr_i, write_addr_i;
    logic [4:0] immediate_i;
    logic       memwrite_i, memread_i, done_i;
    logic       wb_regwrite_i;
    logic [2:0] wb_addr_i;
    logic [7:0] wb_data_i;
    logic [7:0] alu_result_o, store_data_o;
    logic [2:0] write_addr_o;
    logic       regwrite_o, write_data_control_o, memwrite_o, memread_o;
    logic       cb_o, done_o, busy_o;

    int errors = 0;
    int checks = 0;

    // Model of the architecturally visible EX/MEM state
    int m_res, m_store, m_waddr, m_rw, m_wdc, m_mw, m_mr, m_cb, m_done;
    int e_res, e_store, e_waddr, e_rw, e_wdc, e_mw, e_mr, e_cb, e_done;

    ex_mem_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .alucontrol_i(alucontrol_i), .regwrite_i(regwrite_i),
        .write_data_control_i(write_data_control_i), .CBwrite_i(CBwrite_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .write_addr_i(write_addr_i),
        .immediate_i(immediate_i), .memwrite_i(memwrite_i), .memread_i(memread_i),
        .done_i(done_i), .wb_regwrite_i(wb_regwrite_i), .wb_addr_i(wb_addr_i),
        .wb_data_i(wb_data_i), .alu_result_o(alu_result_o), .store_data_o(store_data_o),
        .write_addr_o(write_addr_o), .regwrite_o(regwrite_o),
        .write_data_control_o(write_data_control_o), .memwrite_o(memwrite_o),
        .memread_o(memread_o), .cb_o(cb_o), .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fwd(input int addr, input int data);
        if (m_rw == 1 && m_wdc == 0 && m_waddr == addr) return m_res;
        if (wb_regwrite_i == 1'b1 && int'(wb_addr_i) == addr) return int'(wb_data_i);
        return data;
    endfunction

    function automatic int alu_ref(input int op, input int a, input int b, input int imm);
        case (op)
            0:  return (a + b) % 256;
            1:  return (a - b + 256) % 256;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return 255 - a;
            6:  return (a * (1 << (imm % 8))) % 256;
            7:  return a / (1 << (imm % 8));
            8:  return (a + imm) % 256;
            9:  return imm;
            10: return b;
            default: return 0;
        endcase
    endfunction

    function automatic int cb_ref(input int op, input int a, input int b, input int res);
        if (op == 11) return (a < b) ? 1 : 0;
        if (op == 12) return (a == b) ? 1 : 0;
        return (res == 0) ? 1 : 0;
    endfunction

    task automatic clr();
        rst_i = 0; stall_i = 0; flush_i = 0; alucontrol_i = 0;
        regwrite_i = 0; write_data_control_i = 0; CBwrite_i = 0;
        rs_data_i = 0; rt_data_i = 0; rs_addr_i = 0; rt_addr_i = 0;
        write_addr_i = 0; immediate_i = 0; memwrite_i = 0; memread_i = 0;
        done_i = 0; wb_regwrite_i = 0; wb_addr_i = 0; wb_data_i = 0;
    endtask

    task automatic model_reset();
        m_res = 0; m_store = 0; m_waddr = 0; m_rw = 0; m_wdc = 0;
        m_mw = 0; m_mr = 0; m_cb = 0; m_done = 0;
    endtask

    // Predict from current inputs, clock once, compare every output, commit
    task automatic tick();
        int a, b;
        e_res = m_res; e_store = m_store; e_waddr = m_waddr; e_rw = m_rw;
        e_wdc = m_wdc; e_mw = m_mw; e_mr = m_mr; e_cb = m_cb; e_done = m_done;
        if (rst_i) begin
            e_res = 0; e_store = 0; e_waddr = 0; e_rw = 0; e_wdc = 0;
            e_mw = 0; e_mr = 0; e_cb = 0; e_done = 0;
        end else if (!stall_i) begin
            if (flush_i) begin
                e_res = 0; e_store = 0; e_waddr = 0; e_rw = 0; e_wdc = 0;
                e_mw = 0; e_mr = 0;
            end else begin
                a = fwd(int'(rs_addr_i), int'(rs_data_i));
                b = fwd(int'(rt_addr_i), int'(rt_data_i));
                e_res   = alu_ref(int'(alucontrol_i), a, b, int'(immediate_i));
                e_store = b;
                e_waddr = int'(write_addr_i);
                e_rw = int'(regwrite_i); e_wdc = int'(write_data_control_i);
                e_mw = int'(memwrite_i); e_mr = int'(memread_i);
                if (CBwrite_i) e_cb = cb_ref(int'(alucontrol_i), a, b, e_res);
                if (done_i) e_done = 1;
            end
        end
        @(posedge clk_i);
        #1;
        chk("alu_result", int'(alu_result_o), e_res);
        chk("store_data", int'(store_data_o), e_store);
        chk("write_addr", int'(write_addr_o), e_waddr);
        chk("regwrite", int'(regwrite_o), e_rw);
        chk("wdc", int'(write_data_control_o), e_wdc);
        chk("memwrite", int'(memwrite_o), e_mw);
        chk("memread", int'(memread_o), e_mr);
        chk("cb", int'(cb_o), e_cb);
        chk("done", int'(done_o), e_done);
        chk("busy", int'(busy_o), 0);
        m_res = e_res; m_store = e_store; m_waddr = e_waddr; m_rw = e_rw;
        m_wdc = e_wdc; m_mw = e_mw; m_mr = e_mr; m_cb = e_cb; m_done = e_done;
    endtask

    initial begin
        int held_res;
`ifdef MUL_EN
        int busy_cnt;
`endif
        clr();
        model_reset();
        rst_i = 1;
        tick();
        tick();
        chk("reset_result", int'(alu_result_o), 0);

        // ADD r1=5 + r2=7 without hazards
        clr(); alucontrol_i = 4'h0; rs_addr_i = 1; rs_data_i = 5;
        rt_addr_i = 2; rt_data_i = 7; write_addr_i = 1; regwrite_i = 1;
        tick();
        chk("add_result", int'(alu_result_o), 12);
        chk("add_regwrite", int'(regwrite_o), 1);
        chk("add_waddr", int'(write_addr_o), 1);

        // EX/MEM forward, then EX/MEM beating WB
        for (int pass = 0; pass < 2; pass++) begin
            clr(); tick();
            alucontrol_i = 4'h0; rs_addr_i = 1; rs_data_i = 5;
            rt_addr_i = 2; rt_data_i = 7; write_addr_i = 3; regwrite_i = 1;
            tick();
            chk("add_r3", int'(alu_result_o), 12);
            clr(); alucontrol_i = 4'h1; rs_addr_i = 3; rs_data_i = 0;
            rt_addr_i = 1; rt_data_i = 5; write_addr_i = 4; regwrite_i = 1;
            if (pass == 1) begin
                wb_regwrite_i = 1; wb_addr_i = 3; wb_data_i = 99;
            end
            tick();
            chk(pass == 0 ? "sub_exm_fwd" : "sub_exm_priority", int'(alu_result_o), 7);
        end

        // WB-only forward with wrap
        clr(); tick();
        wb_regwrite_i = 1; wb_addr_i = 2; wb_data_i = 200;
        alucontrol_i = 4'h0; rs_addr_i = 2; rt_addr_i = 2; write_addr_i = 6; regwrite_i = 1;
        tick();
        chk("wb_fwd_wrap", int'(alu_result_o), 144);

        // SLT sets CB, a non-CB instruction leaves it alone
        clr(); tick();
        alucontrol_i = 4'hB; rs_addr_i = 1; rs_data_i = 3; rt_addr_i = 2; rt_data_i = 9;
        CBwrite_i = 1;
        tick();
        chk("slt_cb", int'(cb_o), 1);
        chk("slt_result", int'(alu_result_o), 0);
        clr(); alucontrol_i = 4'h0; rs_data_i = 1; rt_data_i = 2; write_addr_i = 5; regwrite_i = 1;
        tick();
        chk("cb_hold", int'(cb_o), 1);

        // Stall for three cycles with active inputs, including flush
        held_res = m_res;
        for (int i = 0; i < 3; i++) begin
            clr(); stall_i = 1; alucontrol_i = 4'h4; rs_data_i = 8'($urandom);
            regwrite_i = 1; write_addr_i = 7; CBwrite_i = 1; done_i = 1; flush_i = (i == 1);
            tick();
            chk("stall_freeze", int'(alu_result_o), held_res);
        end
        chk("stall_done", int'(done_o), 0);

        // Flush a store, then flush a halt
        clr(); flush_i = 1; memwrite_i = 1; rt_data_i = 77; tick();
        chk("flush_store", int'(memwrite_o), 0);
        clr(); flush_i = 1; done_i = 1; tick();
        chk("flush_done", int'(done_o), 0);
        clr(); done_i = 1; tick();
        chk("done_set", int'(done_o), 1);
        clr(); tick();
        chk("done_sticky", int'(done_o), 1);

`ifdef MUL_EN
        // MUL 13*11 occupies the stage for MUL_CYCLES+1 cycles
        clr(); tick();
        alucontrol_i = 4'hD; rs_addr_i = 1; rs_data_i = 13; rt_addr_i = 2; rt_data_i = 11;
        write_addr_i = 5; regwrite_i = 1;
        @(posedge clk_i); #1;
        clr();
        busy_cnt = 0;
        for (int i = 0; i < 40 && busy_o; i++) begin
            busy_cnt++;
            @(posedge clk_i); #1;
        end
        chk("mul_busy_cycles", busy_cnt, 9);
        chk("mul_result", int'(alu_result_o), 143);
        chk("mul_regwrite", int'(regwrite_o), 1);
        chk("mul_waddr", int'(write_addr_o), 5);
        m_res = 143; m_store = 11; m_waddr = 5; m_rw = 1; m_wdc = 0; m_mw = 0; m_mr = 0;
        alucontrol_i = 4'hD; rs_data_i = 3; rt_data_i = 4;
        @(posedge clk_i); #1;
        clr();
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1;
        model_reset();
        @(posedge clk_i); #1;
        chk("mul_rst_busy", int'(busy_o), 0);
        chk("mul_rst_result", int'(alu_result_o), 0);
        chk("mul_rst_regwrite", int'(regwrite_o), 0);
        chk("mul_rst_done", int'(done_o), 0);
        clr();
`endif

        // Random streams with dense register reuse
        for (int i = 0; i < 400; i++) begin
            clr();
            rst_i   = ($urandom_range(0, 49) == 0);
            stall_i = ($urandom_range(0, 9) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            alucontrol_i = 4'($urandom_range(0, 15));
            if (alucontrol_i == 4'hD) alucontrol_i = 4'hE;
            regwrite_i = 1'($urandom);
            write_data_control_i = ($urandom_range(0, 3) == 0);
            CBwrite_i = 1'($urandom);
            rs_data_i = 8'($urandom); rt_data_i = 8'($urandom);
            rs_addr_i = 3'($urandom); rt_addr_i = 3'($urandom);
            write_addr_i = 3'($urandom); immediate_i = 5'($urandom);
            memwrite_i = 1'($urandom); memread_i = 1'($urandom);
            done_i = ($urandom_range(0, 19) == 0);
            wb_regwrite_i = 1'($urandom); wb_addr_i = 3'($urandom);
            wb_data_i = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Execute stage plus EX/MEM pipeline register for the 8-bit pipelined core. It consumes the registered ID/EX bundle and resolves rs/rt operands through a two-level forwarding network (EX/MEM, then WB). It evaluates the ALU and the compare/branch (CB) flag, then registers the results toward the memory/writeback stage. It also supports stall, flush and a sticky done indication.

Parameters:
DATA_W, 8, datapath width; all arithmetic is modulo 2^DATA_W.
MUL_CYCLES, 8, iterations of the shift-add multiplier; used only with MUL_EN.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
stall_i  in  1  hold all EX/MEM registers; inputs are ignored
flush_i  in  1  load a bubble into EX/MEM
alucontrol_i  in  4  ALU opcode
regwrite_i  in  1  instruction writes the register file
write_data_control_i  in  1  1 = writeback takes memory data (load)
CBwrite_i  in  1  instruction updates the CB flag
rs_data_i, rt_data_i  in  8  operand values read in decode
rs_addr_i, rt_addr_i, write_addr_i  in  3  register addresses
immediate_i  in  5  immediate field
memwrite_i, memread_i  in  1  memory controls
done_i  in  1  halt instruction marker
wb_regwrite_i  in  1  WB stage is writing the register file
wb_addr_i  in  3  WB destination register
wb_data_i  in  8  WB write value
alu_result_o  out  8  ALU result; also the memory address
store_data_o  out  8  forwarded rt value, used as store data
write_addr_o  out  3  destination register
regwrite_o, write_data_control_o, memwrite_o, memread_o  out  1  controls forwarded to MEM
cb_o  out  1  architectural CB flag register
done_o  out  1  sticky halt flag
busy_o  out  1  EX occupied by a multi-cycle op; upstream must stall

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high. On reset every output is 0 and the multiplier FSM returns to IDLE. Reset has priority over stall_i and flush_i and aborts any operation in progress.
- Latency: 1 cycle from ID/EX inputs to the EX/MEM outputs.
- Forwarding, evaluated separately for rs and rt:
  - If regwrite_o=1, write_data_control_o=0 and write_addr_o equals the source address, use alu_result_o.
  - Otherwise, if wb_regwrite_i=1 and wb_addr_i equals the source address, use wb_data_i.
  - Otherwise use the decode-stage value.
  - EX/MEM wins over WB. Load-use hazards are resolved by decode, not here. r0 is an ordinary register.
- ALU opcodes (a = forwarded rs, b = forwarded rt, imm = zero-extended immediate):
  - 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NOT a.
  - 6 SLL a<<imm[2:0]; 7 SRL a>>imm[2:0] (logical).
  - 8 ADDI a+imm; 9 LI imm; A MOV b.
  - B SLT: result 0, cb_next = (a<b) unsigned.
  - C SEQ: result 0, cb_next = (a==b).
  - D MUL: low 8 bits of a*b with MUL_EN; result 0 without it.
  - E, F: result 0.
  - Carries are discarded.
- CB flag: cb_o updates only when CBwrite_i=1 and the instruction is accepted. Opcodes other than B/C with CBwrite_i=1 load cb_next = (result==0). Otherwise cb_o holds.
- stall_i=1: all outputs hold, including cb_o. done_o holds its value.
- flush_i=1 (with stall_i=0): regwrite_o, memwrite_o, memread_o and write_data_control_o clear to 0. Data outputs go to 0. cb_o and done_o are not updated. Flush beats done_i in the same cycle.
- stall_i and flush_i both asserted: stall wins.
- done_o: set when an accepted, non-flushed instruction has done_i=1. It stays set until reset.
- busy_o: 0 in every cycle unless MUL_EN is defined.

Optional Feature:
MUL_EN.
- Defined:
  - Opcode D starts a shift-add multiplier: IDLE -> RUN, then MUL_CYCLES iterations, then DONE -> IDLE.
  - busy_o=1 from the cycle MUL is accepted through RUN. The EX/MEM register inserts bubbles during RUN.
  - In DONE, the product's low 8 bits are registered together with the held controls of the MUL instruction.
  - Operands are captured at acceptance.
  - flush_i in RUN aborts to IDLE with no write. Reset in RUN aborts to IDLE.
- Not defined: opcode D yields result 0, busy_o is tied to 0, and no FSM is built.

Decomposition:
- Shared package core_pkg: ALU opcode constants (ALU_ADD..ALU_MUL), DATA_W, register-address width 3, immediate width 5.
- One natural sub-module: alu8, purely combinational (opcode, a, b, imm -> result, cb_next).
- Forwarding muxes, EX/MEM register and multiplier FSM stay in ex_mem_stage.

Test Plan:
- ADD r1=5, r2=7 with no hazards -> next cycle alu_result_o=12, regwrite_o=1, write_addr_o=1.
- Back-to-back: ADD r3<-r1+r2 (=12), then SUB r4<-r3-r1 with stale rs_data_i=0 -> alu_result_o=7 (EX/MEM forward). The same SUB with WB also writing r3=99 -> still 7 (EX/MEM priority).
- WB forward only: wb_regwrite_i=1, wb_addr_i=2, wb_data_i=200, ADD r2+r2 -> alu_result_o=144 (wrap).
- SLT 3<9 with CBwrite_i=1 -> cb_o=1. A following ADD with CBwrite_i=0 -> cb_o stays 1.
- stall_i for 3 cycles -> outputs frozen. flush_i with a store -> memwrite_o=0. flush_i with done_i=1 -> done_o stays 0.
- MUL_EN: MUL 13*11 -> busy_o high for MUL_CYCLES+1 cycles, then alu_result_o=143. rst_i mid-RUN -> all outputs 0 and busy_o=0 the next cycle.
